// File: rtl/systolic_axis_bridge.sv
// rtl/systolic_axis_bridge.sv - AXI-Stream front end sequencing an NxN systolic array
module systolic_axis_bridge #(
    parameter int N         = 3,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 16,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                  axi_clk,
    input  logic                  axi_rst_n,
    input  logic                  s_axis_valid,
    input  logic [2*N*DATA_W-1:0] s_axis_data,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,
    output logic                  m_axis_valid,
    output logic [N*ACC_W-1:0]    m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready,
    output logic                  arr_rst_n,
    output logic                  arr_en,
    output logic [N*DATA_W-1:0]   arr_a,
    output logic [N*DATA_W-1:0]   arr_b,
    input  logic [N*ACC_W-1:0]    arr_c,
    input  logic                  arr_c_valid,
    output logic                  err_len,
    output logic                  err_unexp
);
    localparam int ROW_W  = N * DATA_W;
    localparam int IN_W   = 2 * ROW_W;
    localparam int OUT_W  = N * ACC_W + 1;
    localparam int IN_AW  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int IN_CW  = $clog2(IN_DEPTH + 1);
    localparam int OUT_AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH + 1);
    localparam int CNT_W  = $clog2(2 * N + 1);
    localparam int CAP_W  = $clog2(N + 1);
    localparam int BI_W   = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_COLLECT, S_CLEAR} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [CAP_W-1:0]   cap_cnt;
    logic [BI_W-1:0]    beat_idx;

    logic [IN_W-1:0]    in_mem [IN_DEPTH];
    logic [IN_AW-1:0]   in_wr_ptr, in_rd_ptr;
    logic [IN_CW-1:0]   in_count;
    logic               in_push, in_pop;

    logic [OUT_W-1:0]   out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0]  out_wr_ptr, out_rd_ptr;
    logic [OUT_CW-1:0]  out_count, out_free;
    logic               out_push, out_pop, cap_active;

    assign s_axis_ready = axi_rst_n && (in_count != IN_CW'(IN_DEPTH));
    assign in_push      = s_axis_valid && s_axis_ready;

    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            for (int i = 0; i < IN_DEPTH; i++) in_mem[i] <= '0;
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_count  <= '0;
        end else begin
            if (in_push) begin
                in_mem[in_wr_ptr] <= s_axis_data;
                in_wr_ptr <= (in_wr_ptr == IN_AW'(IN_DEPTH - 1)) ? '0 : in_wr_ptr + IN_AW'(1);
            end
            if (in_pop)
                in_rd_ptr <= (in_rd_ptr == IN_AW'(IN_DEPTH - 1)) ? '0 : in_rd_ptr + IN_AW'(1);
            if (in_push && !in_pop)
                in_count <= in_count + IN_CW'(1);
            else if (!in_push && in_pop)
                in_count <= in_count - IN_CW'(1);
        end
    end

    // TLAST is only checked against the beat counter; it never steers sequencing
    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            beat_idx <= '0;
            err_len  <= 1'b0;
        end else if (in_push) begin
            if (s_axis_last != (beat_idx == BI_W'(N - 1)))
                err_len <= 1'b1;
            beat_idx <= (beat_idx == BI_W'(N - 1)) ? '0 : beat_idx + BI_W'(1);
        end
    end

    assign out_free = OUT_CW'(OUT_DEPTH) - out_count;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        in_pop   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_count >= IN_CW'(N) && out_free >= OUT_CW'(N)) begin
                    state_nx = S_FEED;
                    cnt_nx   = '0;
                    in_pop   = 1'b1;
                end
            end
            S_FEED: begin
                if (cnt == CNT_W'(N - 1)) begin
                    cnt_nx   = '0;
                    state_nx = (N == 1) ? S_COLLECT : S_FLUSH;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                    in_pop = 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt == CNT_W'(2 * N - 3)) begin
                    cnt_nx   = '0;
                    state_nx = S_COLLECT;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_COLLECT: begin
                if (cap_cnt == CAP_W'(N))
                    state_nx = S_CLEAR;
            end
            S_CLEAR:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Array-side outputs are registered from the next state so the pop and arr_en share an edge
    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            arr_en    <= 1'b0;
            arr_a     <= '0;
            arr_b     <= '0;
            arr_rst_n <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            arr_en    <= (state_nx == S_FEED) || (state_nx == S_FLUSH);
            arr_a     <= in_pop ? in_mem[in_rd_ptr][ROW_W-1:0] : '0;
            arr_b     <= in_pop ? in_mem[in_rd_ptr][IN_W-1:ROW_W] : '0;
            arr_rst_n <= (state_nx != S_CLEAR);
        end
    end

    assign cap_active = (state == S_FEED) || (state == S_FLUSH) || (state == S_COLLECT);
    assign out_push   = arr_c_valid && cap_active && (cap_cnt != CAP_W'(N));
    assign out_pop    = m_axis_valid && m_axis_ready;

    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            cap_cnt   <= '0;
            err_unexp <= 1'b0;
        end else begin
            if (state == S_CLEAR)
                cap_cnt <= '0;
            else if (out_push)
                cap_cnt <= cap_cnt + CAP_W'(1);
            if (arr_c_valid && !out_push)
                err_unexp <= 1'b1;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) out_mem[i] <= '0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
        end else begin
            if (out_push) begin
                out_mem[out_wr_ptr] <= {(cap_cnt == CAP_W'(N - 1)), arr_c};
                out_wr_ptr <= (out_wr_ptr == OUT_AW'(OUT_DEPTH - 1)) ? '0 : out_wr_ptr + OUT_AW'(1);
            end
            if (out_pop)
                out_rd_ptr <= (out_rd_ptr == OUT_AW'(OUT_DEPTH - 1)) ? '0 : out_rd_ptr + OUT_AW'(1);
            if (out_push && !out_pop)
                out_count <= out_count + OUT_CW'(1);
            else if (!out_push && out_pop)
                out_count <= out_count - OUT_CW'(1);
        end
    end

    assign m_axis_valid = (out_count != '0);
    assign m_axis_data  = out_mem[out_rd_ptr][N*ACC_W-1:0];
    assign m_axis_last  = out_mem[out_rd_ptr][N*ACC_W];

endmodule

// File: tb/tb_systolic_axis_bridge.sv
// tb/tb_systolic_axis_bridge.sv - directed vector bench for systolic_axis_bridge
module tb_systolic_axis_bridge;
    logic        axi_clk = 1'b0;
    logic        axi_rst_n = 1'b0;
    logic        s_axis_valid = 1'b0, s_axis_last = 1'b0, s_axis_ready;
    logic [47:0] s_axis_data = '0;
    logic        m_axis_valid, m_axis_last, m_axis_ready = 1'b0;
    logic [47:0] m_axis_data;
    logic        arr_rst_n, arr_en, arr_c_valid;
    logic [23:0] arr_a, arr_b;
    logic [47:0] arr_c;
    logic        err_len, err_unexp;

    logic        mdl_valid = 1'b0, inj_valid = 1'b0;
    logic [47:0] mdl_c = '0, inj_c = '0;
    assign arr_c_valid = mdl_valid | inj_valid;
    assign arr_c       = inj_valid ? inj_c : mdl_c;

    systolic_axis_bridge #(.N(3), .DATA_W(8), .ACC_W(16), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
        .axi_clk(axi_clk), .axi_rst_n(axi_rst_n),
        .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
        .s_axis_ready(s_axis_ready),
        .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
        .m_axis_ready(m_axis_ready),
        .arr_rst_n(arr_rst_n), .arr_en(arr_en), .arr_a(arr_a), .arr_b(arr_b),
        .arr_c(arr_c), .arr_c_valid(arr_c_valid),
        .err_len(err_len), .err_unexp(err_unexp)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [2:0][23:0] a;
        logic [2:0][23:0] b;
        logic [2:0][47:0] c;
    } vec_t;
    vec_t vecs [3];

    int tests = 0, fails = 0;
    int en_run = 0, last_run = 0, feed_starts = 0, clr_pulses = 0, pops = 0, start_pops = 0;

    function automatic logic [23:0] r8(input int x0, input int x1, input int x2);
        return {8'(x2), 8'(x1), 8'(x0)};
    endfunction

    function automatic logic [47:0] r16(input int x0, input int x1, input int x2);
        return {16'(x2), 16'(x1), 16'(x0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge axi_clk);
        #1;
    endtask

    // Behavioural array: buffers the N fed rows, then streams C = A x B once flush completes
    logic [2:0][23:0] ma, mb;
    int en_cnt = 0, emit_idx = 0;

    function automatic logic [47:0] mdl_row(input int i);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 3; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < 3; k++) s += int'(ma[i][k*8 +: 8]) * int'(mb[k][j*8 +: 8]);
            r[j*16 +: 16] = 16'(s);
        end
        return r;
    endfunction

    always @(negedge axi_clk) begin
        mdl_valid = 1'b0;
        if (!arr_rst_n) begin
            en_cnt   = 0;
            emit_idx = 0;
        end else if (arr_en) begin
            if (en_cnt < 3) begin
                ma[en_cnt] = arr_a;
                mb[en_cnt] = arr_b;
            end
            en_cnt++;
        end else if (en_cnt == 7 && emit_idx < 3) begin
            mdl_c     = mdl_row(emit_idx);
            mdl_valid = 1'b1;
            emit_idx++;
        end
    end

    always @(negedge axi_clk) begin
        if (arr_en) begin
            en_run++;
            if (en_run == 1) begin
                feed_starts++;
                start_pops = pops;
            end
        end else if (en_run != 0) begin
            last_run = en_run;
            en_run   = 0;
        end
        if (axi_rst_n && !arr_rst_n) clr_pulses++;
        if (m_axis_valid && m_axis_ready) pops++;
    end

    task automatic send_beat(input logic [23:0] a, input logic [23:0] b, input logic last,
                             input int budget, output bit ok);
        s_axis_valid = 1'b1;
        s_axis_data  = {b, a};
        s_axis_last  = last;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge axi_clk);
            if (s_axis_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge axi_clk);
        #1;
        s_axis_valid = 1'b0;
    endtask

    task automatic send_matrix(input vec_t v, input logic [2:0] lasts);
        bit ok;
        for (int r = 0; r < 3; r++) begin
            send_beat(v.a[r], v.b[r], lasts[r], 40, ok);
            check("send_accept", 64'(ok), 64'(1));
        end
    endtask

    task automatic recv_row(output logic [47:0] d, output logic l, output bit ok);
        m_axis_ready = 1'b1;
        ok = 1'b0;
        d  = '0;
        l  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge axi_clk);
            if (m_axis_valid) begin
                ok = 1'b1;
                d  = m_axis_data;
                l  = m_axis_last;
                break;
            end
        end
        @(posedge axi_clk);
        #1;
        m_axis_ready = 1'b0;
    endtask

    task automatic recv_matrix(input vec_t v, input string tag);
        logic [47:0] d;
        logic        l;
        bit          ok;
        for (int r = 0; r < 3; r++) begin
            recv_row(d, l, ok);
            check({tag, "_rx_ok"}, 64'(ok), 64'(1));
            check({tag, "_row"}, 64'(d), 64'(v.c[r]));
            check({tag, "_last"}, 64'(l), 64'(r == 2));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base_clr, base_feed, base_pops, unstable, accepted;
        bit ok, found;
        logic [47:0] first_d;
        logic        first_l;

        vecs[0].a[0] = r8(1, 0, 0);  vecs[0].a[1] = r8(0, 1, 0);  vecs[0].a[2] = r8(0, 0, 1);
        vecs[0].b[0] = r8(1, 2, 3);  vecs[0].b[1] = r8(4, 5, 6);  vecs[0].b[2] = r8(7, 8, 9);
        vecs[0].c[0] = r16(1, 2, 3); vecs[0].c[1] = r16(4, 5, 6); vecs[0].c[2] = r16(7, 8, 9);
        vecs[1].a[0] = r8(1, 2, 0);  vecs[1].a[1] = r8(0, 1, 1);  vecs[1].a[2] = r8(2, 0, 1);
        vecs[1].b[0] = r8(1, 0, 2);  vecs[1].b[1] = r8(3, 1, 0);  vecs[1].b[2] = r8(0, 2, 1);
        vecs[1].c[0] = r16(7, 2, 2); vecs[1].c[1] = r16(3, 3, 1); vecs[1].c[2] = r16(2, 2, 5);
        vecs[2].a[0] = r8(255, 255, 255); vecs[2].a[1] = r8(0, 0, 0); vecs[2].a[2] = r8(1, 1, 1);
        vecs[2].b[0] = r8(255, 255, 255); vecs[2].b[1] = r8(255, 255, 255); vecs[2].b[2] = r8(255, 255, 255);
        vecs[2].c[0] = r16(64003, 64003, 64003); vecs[2].c[1] = r16(0, 0, 0); vecs[2].c[2] = r16(765, 765, 765);

        // reset held for three edges
        axi_rst_n = 1'b0;
        tick(3);
        check("rst_s_ready", 64'(s_axis_ready), 64'(0));
        check("rst_m_valid", 64'(m_axis_valid), 64'(0));
        check("rst_m_data", 64'(m_axis_data), 64'(0));
        check("rst_m_last", 64'(m_axis_last), 64'(0));
        check("rst_arr_en", 64'(arr_en), 64'(0));
        check("rst_arr_a", 64'(arr_a), 64'(0));
        check("rst_arr_b", 64'(arr_b), 64'(0));
        check("rst_arr_rst_n", 64'(arr_rst_n), 64'(0));
        check("rst_err_len", 64'(err_len), 64'(0));
        check("rst_err_unexp", 64'(err_unexp), 64'(0));
        axi_rst_n = 1'b1;
        @(negedge axi_clk);
        check("rel_s_ready", 64'(s_axis_ready), 64'(1));
        @(posedge axi_clk);
        #1;

        // table of single matrices
        for (int t = 0; t < 3; t++) begin
            base_clr = clr_pulses;
            send_matrix(vecs[t], 3'b100);
            recv_matrix(vecs[t], "vec");
            tick(4);
            check("vec_en_len", 64'(last_run), 64'(7));
            check("vec_clr_pulse", 64'(clr_pulses - base_clr), 64'(1));
        end

        // backpressure with two matrices queued
        m_axis_ready = 1'b0;
        base_feed = feed_starts;
        base_pops = pops;
        send_matrix(vecs[0], 3'b100);
        send_matrix(vecs[1], 3'b100);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge axi_clk);
            if (m_axis_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", 64'(found), 64'(1));
        first_d  = m_axis_data;
        first_l  = m_axis_last;
        unstable = 0;
        repeat (20) begin
            @(negedge axi_clk);
            if (!m_axis_valid || m_axis_data !== first_d || m_axis_last !== first_l) unstable++;
        end
        check("bp_stable", 64'(unstable), 64'(0));
        check("bp_head", 64'(first_d), 64'(vecs[0].c[0]));
        check("bp_feeds_held", 64'(feed_starts - base_feed), 64'(1));
        @(posedge axi_clk);
        #1;
        recv_matrix(vecs[0], "bp0");
        recv_matrix(vecs[1], "bp1");
        check("bp_feeds_total", 64'(feed_starts - base_feed), 64'(2));
        check("bp_free_wait", 64'((start_pops - base_pops) >= 2), 64'(1));

        // input FIFO fills while output is stalled
        m_axis_ready = 1'b0;
        send_matrix(vecs[2], 3'b100);
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) send_beat(vecs[0].a[k], vecs[0].b[k], k == 2, 12, ok);
            else       send_beat(vecs[1].a[k-3], vecs[1].b[k-3], k == 5, 12, ok);
            if (!ok) break;
            accepted++;
        end
        check("full_accepted", 64'(accepted), 64'(4));
        check("full_ready_low", 64'(s_axis_ready), 64'(0));
        recv_matrix(vecs[2], "full2");
        recv_matrix(vecs[0], "full0");
        for (int r = 1; r < 3; r++) begin
            send_beat(vecs[1].a[r], vecs[1].b[r], r == 2, 40, ok);
            check("full_tail_accept", 64'(ok), 64'(1));
        end
        recv_matrix(vecs[1], "full1");

        // framing error and unexpected strobe
        check("err_len_pre", 64'(err_len), 64'(0));
        check("err_unexp_pre", 64'(err_unexp), 64'(0));
        send_matrix(vecs[1], 3'b110);
        recv_matrix(vecs[1], "elen");
        check("err_len_set", 64'(err_len), 64'(1));
        tick(6);
        check("err_len_sticky", 64'(err_len), 64'(1));
        inj_c     = 48'h1234_5678_9abc;
        inj_valid = 1'b1;
        tick(1);
        inj_valid = 1'b0;
        check("err_unexp_set", 64'(err_unexp), 64'(1));
        check("unexp_no_beat", 64'(m_axis_valid), 64'(0));
        tick(3);
        check("unexp_no_beat_later", 64'(m_axis_valid), 64'(0));

        // reset in the middle of FEED
        send_matrix(vecs[0], 3'b100);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge axi_clk);
            if (arr_en) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_feed_seen", 64'(found), 64'(1));
        @(posedge axi_clk);
        #1;
        axi_rst_n = 1'b0;
        tick(1);
        check("mid_rst_arr_en", 64'(arr_en), 64'(0));
        check("mid_rst_m_valid", 64'(m_axis_valid), 64'(0));
        check("mid_rst_s_ready", 64'(s_axis_ready), 64'(0));
        check("mid_rst_err_len", 64'(err_len), 64'(0));
        axi_rst_n = 1'b1;
        tick(15);
        check("mid_rst_no_output", 64'(m_axis_valid), 64'(0));
        send_matrix(vecs[2], 3'b100);
        recv_matrix(vecs[2], "post_rst");
        tick(3);
        check("post_rst_en_len", 64'(last_run), 64'(7));
        check("post_rst_err_len", 64'(err_len), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
